sqr_stepper: RTL and testbench
==============================

# sqr_stepper

Iterative integer squarer with step navigation, the inverse companion to the printsqrt root stepper. It holds an operand `x`, moves it by `delta` on `next`/`previous` commands, and computes `x*x` with a bit-serial shift-add multiplier. Used to cross-check root results: a root stepped through printsqrt is squared here and compared against the original `n`.

## Interface
- `W`, default 32: operand width; result width is 2*W.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  level-sampled; loads `x <= n` and starts a squaring.
- `next`  in  1  level-sampled; `x <= x + delta`, then square.
- `previous`  in  1  level-sampled; `x <= x - delta`, then square.
- `n`  in  W  load value.
- `delta`  in  W  step size, unsigned.
- `x`  out  W  current operand.
- `sq`  out  2W  last completed square of `x`.
- `valid`  out  1  `sq` corresponds to the current `x`.
- `busy`  out  1  multiplication in progress; commands ignored.

## Operation
- States: IDLE, MUL.
- Reset (`reset`=0, asynchronous): state IDLE, `x`=0, `sq`=0, `valid`=0, `busy`=0, bit counter=0, accumulator=0. Effective immediately, including mid-multiplication; the partial product is discarded.
- IDLE, command priority on a rising edge: `load` > (`next` xor `previous`). `next` and `previous` both high without `load` is a no-op. No command: hold everything.
- Command accepted: update `x`, load multiplicand/multiplier copies of the new `x`, clear accumulator, counter=0, `busy`<=1, `valid`<=0, go to MUL.
- MUL, each cycle: if multiplier bit[counter] is set, add `x << counter` to the 2W-bit accumulator; counter++. After the cycle with counter=W-1: `sq` <= final accumulator, `valid`<=1, `busy`<=0, go to IDLE.
- Commands arriving during MUL are ignored, not queued. `x` is stable during MUL.
- Arithmetic: `x +/- delta` is mod 2^W (wrap) by default. The product is exact in 2W bits, with no overflow.
- `valid` and `sq` hold until the next accepted command. A no-op command does not clear `valid`.

## Timing
- Command accepted at edge t0: `x`, `busy`=1, `valid`=0 are visible after t0.
- `sq`, `valid`=1, `busy`=0 are visible after edge t0+W (W=32: 32 cycles).
- Earliest next accept is at edge t0+W+1. Throughput is one square per W+1 cycles with back-to-back commands.
- Level-held `next` re-triggers every W+1 cycles while held.
- Reset deassertion is synchronized externally. The first accepted command is possible at the first edge after release.

## Configuration
- `SQR_STEPPER_SATURATE_EN` defined: `next` clamps `x` at 2^W-1 and `previous` clamps at 0, so no wrap. Clamped commands still start a squaring.
- Undefined: modular wrap as above.

## Test plan
- Reset, then `load` with `n`=12 -> after 32 cycles `x`=12, `sq`=144, `valid`=1, `busy`=0.
- From `x`=12, `delta`=3, pulse `next` -> `x`=15, `valid` drops for 32 cycles, then `sq`=225. Pulse `previous` twice, the second only after `busy` falls -> `x`=9, `sq`=81.
- `x`=1, `delta`=2, `previous`: without macro `x`=0xFFFFFFFF, `sq`=0xFFFFFFFE00000001. With `SQR_STEPPER_SATURATE_EN`, `x`=0, `sq`=0.
- `next` and `previous` both high in IDLE -> no change, `valid` stays 1. `load` plus `next` together -> `x`=`n`.
- Pulse `next` while `busy`=1 -> ignored; `x` unchanged and the result matches the original command.
- Assert `reset` low at cycle 10 of MUL -> all outputs 0 immediately. Then `load` with `n`=0xFFFF -> `sq`=0xFFFE0001.

Source files
------------

// File: rtl/sqr_stepper.sv
// Iterative squarer: holds an operand x, steps it by delta on next/previous, and squares it with a W-cycle shift-add.
// Optional macro SQR_STEPPER_SATURATE_EN clamps x at 0 and 2^W-1 instead of wrapping.
module sqr_stepper #(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             next,
    input  logic             previous,
    input  logic [W-1:0]     n,
    input  logic [W-1:0]     delta,
    output logic [W-1:0]     x,
    output logic [2*W-1:0]   sq,
    output logic             valid,
    output logic             busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  sq_q, sq_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic [2*W-1:0]  acc_sum_s;

    function automatic logic [W-1:0] step_up(input logic [W-1:0] a, input logic [W-1:0] d);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, d};
`ifdef SQR_STEPPER_SATURATE_EN
        step_up = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
        step_up = sum[W-1:0];
`endif
    endfunction

    function automatic logic [W-1:0] step_down(input logic [W-1:0] a, input logic [W-1:0] d);
`ifdef SQR_STEPPER_SATURATE_EN
        step_down = (d > a) ? {W{1'b0}} : (a - d);
`else
        step_down = a - d;
`endif
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            x_q      <= {W{1'b0}};
            mplier_q <= {W{1'b0}};
            acc_q    <= {(2*W){1'b0}};
            cnt_q    <= {CW{1'b0}};
            sq_q     <= {(2*W){1'b0}};
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sq_q     <= sq_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    // Partial product: x stays put during MUL, so it doubles as the multiplicand
    always_comb begin
        acc_sum_s = acc_q;
        if (mplier_q[cnt_q]) begin
            acc_sum_s = acc_q + ({{W{1'b0}}, x_q} << cnt_q);
        end else begin
            acc_sum_s = acc_q;
        end
    end

    // Command decode and multiply sequencing
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sq_d     = sq_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (load || (next ^ previous)) begin
                    if (load) begin
                        x_d = n;
                    end else if (next) begin
                        x_d = step_up(x_q, delta);
                    end else begin
                        x_d = step_down(x_q, delta);
                    end
                    mplier_d = x_d;
                    acc_d    = {(2*W){1'b0}};
                    cnt_d    = {CW{1'b0}};
                    busy_d   = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d = acc_sum_s;
                if (cnt_q == CW'(W - 1)) begin
                    sq_d    = acc_sum_s;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d = MUL;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign x     = x_q;
    assign sq    = sq_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sqr_stepper.sv
// Bench for sqr_stepper: directed and random commands against an arithmetic reference model.
module tb_sqr_stepper;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        next = 1'b0;
    logic        previous = 1'b0;
    logic [31:0] n = 32'd0;
    logic [31:0] delta = 32'd0;
    logic [31:0] x;
    logic [63:0] sq;
    logic        valid;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_x = 32'd0;
    logic [63:0] m_sq = 64'd0;
    logic        m_valid = 1'b0;

    sqr_stepper #(.W(32)) dut (
        .clk(clk), .reset(reset), .load(load), .next(next), .previous(previous),
        .n(n), .delta(delta), .x(x), .sq(sq), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_up(input logic [31:0] a, input logic [31:0] d);
        longint unsigned s;
        s = longint'(a) + longint'(d);
`ifdef SQR_STEPPER_SATURATE_EN
        if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] ref_down(input logic [31:0] a, input logic [31:0] d);
        longint signed s;
        s = longint'(a) - longint'(d);
`ifdef SQR_STEPPER_SATURATE_EN
        if (s < 0) s = 0;
`else
        if (s < 0) s = s + 64'sh1_0000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_x"}, {32'd0, x}, {32'd0, m_x});
        chk({tag, "_sq"}, sq, m_sq);
        chk({tag, "_valid"}, {63'd0, valid}, {63'd0, m_valid});
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    // Issue one command for a cycle; poke>0 pulses next at that MUL cycle.
    task automatic run_cmd(input string tag, input logic l, input logic nx, input logic pv,
                           input logic [31:0] nv, input logic [31:0] dv, input int poke);
        logic [31:0] new_x;
        load = l; next = nx; previous = pv; n = nv; delta = dv;
        @(posedge clk); #1;
        load = 1'b0; next = 1'b0; previous = 1'b0;
        if (l) new_x = nv;
        else if (nx && !pv) new_x = ref_up(m_x, dv);
        else if (pv && !nx) new_x = ref_down(m_x, dv);
        else begin
            chk_idle({tag, "_noop"});
            return;
        end
        m_x = new_x;
        m_valid = 1'b0;
        chk({tag, "_acc_x"}, {32'd0, x}, {32'd0, m_x});
        chk({tag, "_acc_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_acc_valid"}, {63'd0, valid}, 64'd0);
        for (int k = 1; k < 32; k++) begin
            if (k == poke) begin
                next = 1'b1;
                delta = 32'd7;
            end
            @(posedge clk); #1;
            next = 1'b0;
            if (k == 31) begin
                chk({tag, "_mid_busy"}, {63'd0, busy}, 64'd1);
                chk({tag, "_mid_x"}, {32'd0, x}, {32'd0, m_x});
            end
        end
        @(posedge clk); #1;
        m_sq = {32'd0, m_x} * {32'd0, m_x};
        m_valid = 1'b1;
        chk_idle({tag, "_done"});
    endtask

    initial begin
        logic [31:0] rn, rd;
        int op;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b1;

        run_cmd("load12", 1'b1, 1'b0, 1'b0, 32'd12, 32'd0, 0);
        chk("sq144", sq, 64'd144);
        run_cmd("next3", 1'b0, 1'b1, 1'b0, 32'd0, 32'd3, 0);
        chk("sq225", sq, 64'd225);
        run_cmd("prev3a", 1'b0, 1'b0, 1'b1, 32'd0, 32'd3, 0);
        run_cmd("prev3b", 1'b0, 1'b0, 1'b1, 32'd0, 32'd3, 0);
        chk("sq81", sq, 64'd81);

        run_cmd("both", 1'b0, 1'b1, 1'b1, 32'd0, 32'd5, 0);
        run_cmd("loadnext", 1'b1, 1'b1, 1'b0, 32'd1, 32'd5, 0);
        run_cmd("wrap", 1'b0, 1'b0, 1'b1, 32'd0, 32'd2, 0);
`ifdef SQR_STEPPER_SATURATE_EN
        chk("wrap_sq", sq, 64'd0);
`else
        chk("wrap_sq", sq, 64'hFFFF_FFFE_0000_0001);
`endif
        run_cmd("sat_up", 1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFF0, 0);
        run_cmd("poke", 1'b1, 1'b0, 1'b0, 32'd1234, 32'd0, 5);
        run_cmd("poke_last", 1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 31);

        // Asynchronous reset in the middle of a multiplication
        load = 1'b1; n = 32'd99;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        m_x = 32'd0; m_sq = 64'd0; m_valid = 1'b0;
        chk_idle("midreset");
        @(posedge clk); #2;
        reset = 1'b1;
        run_cmd("loadFFFF", 1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 32'd0, 0);
        chk("sqFFFF", sq, 64'hFFFE_0001);

        for (int i = 0; i < 24; i++) begin
            rn = $urandom;
            rd = $urandom;
            op = $urandom_range(0, 4);
            if (op == 4) rd = rd & 32'h0000_00FF;
            case (op)
                0: run_cmd("rnd_load", 1'b1, 1'($urandom_range(0, 1)), 1'b0, rn, rd, 0);
                1: run_cmd("rnd_next", 1'b0, 1'b1, 1'b0, rn, rd, 0);
                2: run_cmd("rnd_prev", 1'b0, 1'b0, 1'b1, rn, rd, 0);
                3: run_cmd("rnd_both", 1'b0, 1'b1, 1'b1, rn, rd, 0);
                default: run_cmd("rnd_small", 1'b0, 1'b1, 1'b0, rn, rd, $urandom_range(1, 31));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
